mdio_peripheral: RTL and testbench

- PHY-side MDIO management target that sits directly downstream of mdio_controller.
- Consumes MDC, MDIO_OUT and MDIO_OE from the controller and deframes the 32-bit Clause-22 frame: ST(2), OP(2), PHYAD(5), REGAD(5), TA(2), DATA(16), MSB first.
- On a write frame it issues a register write to a local register file.
- On a read frame it fetches the register and serialises it back on MDIO_IN.

---
 rtl/mdio_pkg.sv | 59 +++++
 rtl/mdio_peripheral_if.sv | 33 +++
 rtl/mdc_edge_detect.sv | 28 ++
 rtl/mdio_peripheral.sv | 205 ++++++++++++++++++++
 tb/tb_mdio_peripheral.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// ============================================================================
// Module : mdio_pkg
// Brief  : Clause-22 frame layout, opcodes and FSM encodings shared by the
//          MDIO controller and peripheral.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdio_pkg;

  localparam int FRAME_W   = 32;
  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int PHYAD_LSB = 23;
  localparam int REGAD_MSB = 22;
  localparam int REGAD_LSB = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [5:0] EDGE_HDR  = 6'd14;
  localparam logic [5:0] EDGE_TA1  = 6'd15;
  localparam logic [5:0] EDGE_TA2  = 6'd16;
  localparam logic [5:0] EDGE_LAST = 6'd32;

  // Header fields sit this many positions below their final frame slot at edge 14.
  localparam int HDR_SHIFT = FRAME_W - 14;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_HEADER     = 3'd1;
  localparam logic [2:0] S_TA_WR      = 3'd2;
  localparam logic [2:0] S_TA_RD      = 3'd3;
  localparam logic [2:0] S_WRITE_DATA = 3'd4;
  localparam logic [2:0] S_READ_DATA  = 3'd5;
  localparam logic [2:0] S_DISCARD    = 3'd6;

  function automatic logic [2:0] header_next_state(
    input logic [1:0] st,
    input logic [1:0] op,
    input logic [4:0] phyad,
    input logic [4:0] phy_addr
  );
    if (st != ST_CODE || phyad != phy_addr) return S_DISCARD;
    if (op == OP_WRITE) return S_TA_WR;
    if (op == OP_READ)  return S_TA_RD;
    return S_DISCARD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdio_peripheral_if.sv
// ============================================================================
// Module : mdio_peripheral_if
// Brief  : MDIO serial lines plus the register-file port of the PHY target.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mdio_peripheral_if;

  logic        mdc;
  logic        mdio_oe;
  logic        mdio_out;
  logic        mdio_in;
  logic        mdio_in_en;
  logic [4:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        mem_wr;
  logic        mem_rd;

  modport master (
    output mdc, mdio_oe, mdio_out, rd_data,
    input  mdio_in, mdio_in_en, addr, wr_data, mem_wr, mem_rd
  );

  modport slave (
    input  mdc, mdio_oe, mdio_out, rd_data,
    output mdio_in, mdio_in_en, addr, wr_data, mem_wr, mem_rd
  );

endinterface

`default_nettype wire

// File: rtl/mdc_edge_detect.sv
// ============================================================================
// Module : mdc_edge_detect
// Brief  : Registers MDC on the system clock and flags its rising/falling edges.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdc_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mdc_i,
  output logic rise_o,
  output logic fall_o
);

  logic mdc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mdc_q <= 1'b0;
    else         mdc_q <= mdc_i;
  end

  assign rise_o = mdc_i & ~mdc_q;
  assign fall_o = ~mdc_i & mdc_q;

endmodule

`default_nettype wire

// File: rtl/mdio_peripheral.sv
// ============================================================================
// Module : mdio_peripheral
// Brief  : Clause-22 MDIO target: deframes controller frames into register-file
//          writes/reads and serialises read data back on MDIO_IN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mdio_peripheral_if.slave  bus
);

  logic        w_rise;
  logic        w_fall;

  logic [2:0]  state_q,      state_d;
  logic [5:0]  cnt_q,        cnt_d;
  logic [21:0] sh_q,         sh_d;
  logic [4:0]  addr_q,       addr_d;
  logic [15:0] wr_data_q,    wr_data_d;
  logic        mem_wr_q,     mem_wr_d;
  logic        mem_rd_q,     mem_rd_d;
  logic        rd_cap_q,     rd_cap_d;
  logic [15:0] out_q,        out_d;
  logic        mdio_in_q,    mdio_in_d;
  logic        mdio_in_en_q, mdio_in_en_d;

  logic [22:0] w_frame;
  logic [5:0]  w_cnt_inc;
  logic        w_abort;

  mdc_edge_detect u_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .mdc_i  (bus.mdc),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

  // Only frame bits 22:0 are ever needed at once (REGAD + TA + DATA at edge 32).
  assign w_frame   = {sh_q, bus.mdio_out};
  assign w_cnt_inc = cnt_q + 6'd1;
  assign w_abort   = !bus.mdio_oe && (state_q != S_IDLE) && (state_q != S_DISCARD);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    mem_wr_d     = 1'b0;
    mem_rd_d     = 1'b0;
    rd_cap_d     = mem_rd_q;
    out_d        = out_q;
    mdio_in_d    = mdio_in_q;
    mdio_in_en_d = mdio_in_en_q;

    if (rd_cap_q) out_d = bus.rd_data;

    if (w_abort) begin
      state_d      = S_IDLE;
      cnt_d        = 6'd0;
      mdio_in_d    = 1'b0;
      mdio_in_en_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = 6'd0;
          if (w_rise && bus.mdio_oe) begin
            sh_d    = w_frame[21:0];
            cnt_d   = 6'd1;
            state_d = S_HEADER;
          end
        end

        S_HEADER: begin
          if (w_rise) begin
            sh_d  = w_frame[21:0];
            cnt_d = w_cnt_inc;
            if (w_cnt_inc == EDGE_HDR) begin
              state_d = header_next_state(
                w_frame[ST_MSB-HDR_SHIFT -: 2],
                w_frame[OP_MSB-HDR_SHIFT -: 2],
                w_frame[PHYAD_MSB-HDR_SHIFT -: 5],
                PHY_ADDR);
              if (state_d == S_TA_RD) begin
                addr_d   = w_frame[REGAD_MSB-HDR_SHIFT -: 5];
                mem_rd_d = 1'b1;
              end
            end
          end
        end

        S_TA_WR: begin
          if (w_rise) begin
            sh_d  = w_frame[21:0];
            cnt_d = w_cnt_inc;
            if (w_cnt_inc == EDGE_TA2) state_d = S_WRITE_DATA;
          end
        end

        S_WRITE_DATA: begin
          if (w_rise) begin
            sh_d  = w_frame[21:0];
            cnt_d = w_cnt_inc;
            if (w_cnt_inc == EDGE_LAST) begin
              addr_d    = w_frame[REGAD_MSB:REGAD_LSB];
              wr_data_d = w_frame[DATA_MSB:DATA_LSB];
              mem_wr_d  = 1'b1;
              cnt_d     = 6'd0;
              state_d   = S_IDLE;
            end
          end
        end

        S_TA_RD: begin
          if (w_rise) begin
            cnt_d = w_cnt_inc;
          end else if (w_fall) begin
            if (cnt_q == EDGE_TA1) begin
              mdio_in_en_d = 1'b1;
              mdio_in_d    = 1'b0;
            end else if (cnt_q == EDGE_TA2) begin
              mdio_in_d = out_q[15];
              out_d     = {out_q[14:0], 1'b0};
              state_d   = S_READ_DATA;
            end
          end
        end

        S_READ_DATA: begin
          if (w_rise) begin
            cnt_d = w_cnt_inc;
          end else if (w_fall) begin
            if (cnt_q == EDGE_LAST) begin
              mdio_in_en_d = 1'b0;
              mdio_in_d    = 1'b0;
              cnt_d        = 6'd0;
              state_d      = S_IDLE;
            end else begin
              mdio_in_d = out_q[15];
              out_d     = {out_q[14:0], 1'b0};
            end
          end
        end

        S_DISCARD: begin
          if (!bus.mdio_oe) begin
            cnt_d   = 6'd0;
            state_d = S_IDLE;
          end
        end

        default: begin
          cnt_d   = 6'd0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      rd_cap_q     <= 1'b0;
      out_q        <= '0;
      mdio_in_q    <= 1'b0;
      mdio_in_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      mem_wr_q     <= mem_wr_d;
      mem_rd_q     <= mem_rd_d;
      rd_cap_q     <= rd_cap_d;
      out_q        <= out_d;
      mdio_in_q    <= mdio_in_d;
      mdio_in_en_q <= mdio_in_en_d;
    end
  end

  assign bus.mdio_in    = mdio_in_q;
  assign bus.mdio_in_en = mdio_in_en_q;
  assign bus.addr       = addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_rd     = mem_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_mdio_peripheral.sv
// ============================================================================
// Module : tb_mdio_peripheral
// Brief  : Scoreboard bench for mdio_peripheral with a behavioural register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdio_peripheral;

  localparam int HALF = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdio_peripheral_if bus ();

  mdio_peripheral #(.PHY_ADDR(5'd1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef enum logic [1:0] {K_WR, K_RD, K_WORD} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic [4:0]  addr;
    logic [16:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] mem [32];
  logic [16:0] obs_word;
  logic        word_done = 1'b0;
  logic        en_seen   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                     input logic [4:0] phy, input logic [4:0] ra,
                                     input logic [15:0] d);
    return {st, op, phy, ra, 2'b10, d};
  endfunction

  // Register file: read data valid one CLK after MEM_RD.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
      mem[3]      <= 16'hBEEF;
      bus.rd_data <= 16'h0000;
    end else begin
      if (bus.mem_wr) mem[bus.addr] <= bus.wr_data;
      if (bus.mem_rd) bus.rd_data <= mem[bus.addr];
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a strobe or read word.
  initial begin : monitor
    exp_t e;
    logic prev_wr;
    logic prev_rd;
    prev_wr = 1'b0;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mdio_in_en) en_seen = 1'b1;
      if (bus.mem_wr || bus.mem_rd) begin
        check("strobe_exclusive", {31'd0, bus.mem_wr & bus.mem_rd}, 32'd0);
        check("strobe_width", {31'd0, (bus.mem_wr & prev_wr) | (bus.mem_rd & prev_rd)}, 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got wr=%b rd=%b addr=%h, want none",
                   bus.mem_wr, bus.mem_rd, bus.addr);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", {30'd0, bus.mem_wr ? K_WR : K_RD}, {30'd0, e.kind});
          check("strobe_addr", {27'd0, bus.addr}, {27'd0, e.addr});
          if (bus.mem_wr) check("wr_data", {16'd0, bus.wr_data}, {16'd0, e.data[15:0]});
        end
      end
      if (word_done) begin
        word_done = 1'b0;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read_word: got %h, want none", obs_word);
        end else begin
          e = sb.pop_front();
          check("word_kind", {30'd0, K_WORD}, {30'd0, e.kind});
          check("read_word", {15'd0, obs_word}, {15'd0, e.data});
        end
      end
      prev_wr = bus.mem_wr;
      prev_rd = bus.mem_rd;
    end
  end

  // Drives nbits of a frame like the controller; samples MDIO_IN on each rise.
  task automatic run_frame(input logic [31:0] f, input int nbits,
                           input bit is_read, input bit do_reset);
    logic en_ok;
    en_ok    = 1'b1;
    en_seen  = 1'b0;
    obs_word = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mdio_oe  = 1'b1;
      bus.mdio_out = f[31-i];
      repeat (HALF) @(negedge clk);
      if (is_read && i == 14) en_ok &= !bus.mdio_in_en;
      if (is_read && i >= 15) begin
        en_ok &= bus.mdio_in_en;
        obs_word = {obs_word[15:0], bus.mdio_in};
      end
      bus.mdc = 1'b1;
      if (do_reset && i == nbits - 1) begin
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mdio_in_en", {31'd0, bus.mdio_in_en}, 32'd0);
        check("rst_mdio_in",    {31'd0, bus.mdio_in},    32'd0);
        check("rst_mem_wr",     {31'd0, bus.mem_wr},     32'd0);
        check("rst_mem_rd",     {31'd0, bus.mem_rd},     32'd0);
        break;
      end
      repeat (HALF) @(negedge clk);
      bus.mdc = 1'b0;
    end
    if (do_reset) begin
      bus.mdc     = 1'b0;
      bus.mdio_oe = 1'b0;
      repeat (HALF) @(negedge clk);
      rst_n = 1'b1;
      repeat (HALF) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
      if (is_read && nbits == 32) begin
        en_ok &= !bus.mdio_in_en;
        check("read_en_window", {31'd0, en_ok}, 32'd1);
        word_done = 1'b1;
      end
      bus.mdio_oe  = 1'b0;
      bus.mdio_out = 1'b0;
      repeat (HALF) @(negedge clk);
      if (!is_read) check("en_quiet", {31'd0, en_seen}, 32'd0);
    end
  endtask

  task automatic push(input kind_e k, input logic [4:0] a, input logic [16:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.mdc      = 1'b0;
    bus.mdio_oe  = 1'b0;
    bus.mdio_out = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_mdio_in",    {31'd0, bus.mdio_in},    32'd0);
    check("reset_mdio_in_en", {31'd0, bus.mdio_in_en}, 32'd0);
    check("reset_mem_wr",     {31'd0, bus.mem_wr},     32'd0);
    check("reset_mem_rd",     {31'd0, bus.mem_rd},     32'd0);
    check("reset_addr",       {27'd0, bus.addr},       32'd0);
    check("reset_wr_data",    {16'd0, bus.wr_data},    32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    push(K_WR, 5'h16, 17'h01234);
    run_frame(mk(2'b01, 2'b01, 5'd1, 5'h16, 16'h1234), 32, 1'b0, 1'b0);

    push(K_RD, 5'h03, 17'h0);
    push(K_WORD, 5'h03, {1'b0, 16'hBEEF});
    run_frame(mk(2'b01, 2'b10, 5'd1, 5'h03, 16'h0000), 32, 1'b1, 1'b0);

    push(K_RD, 5'h16, 17'h0);
    push(K_WORD, 5'h16, {1'b0, 16'h1234});
    run_frame(mk(2'b01, 2'b10, 5'd1, 5'h16, 16'h0000), 32, 1'b1, 1'b0);

    // Ignored frames: foreign PHYAD (7 and 20), bad ST, reserved opcodes.
    run_frame(mk(2'b01, 2'b01, 5'd7, 5'h04, 16'hCAFE), 32, 1'b0, 1'b0);
    run_frame(32'h5A5A_1234,                           32, 1'b0, 1'b0);
    run_frame(mk(2'b00, 2'b01, 5'd1, 5'h04, 16'hCAFE), 32, 1'b0, 1'b0);
    run_frame(mk(2'b01, 2'b11, 5'd1, 5'h04, 16'hCAFE), 32, 1'b0, 1'b0);
    run_frame(mk(2'b01, 2'b00, 5'd1, 5'h04, 16'hCAFE), 32, 1'b0, 1'b0);

    run_frame(mk(2'b01, 2'b01, 5'd1, 5'h09, 16'hAAAA), 20, 1'b0, 1'b0);
    push(K_WR, 5'h02, 17'h000FF);
    run_frame(mk(2'b01, 2'b01, 5'd1, 5'h02, 16'h00FF), 32, 1'b0, 1'b0);
    push(K_RD, 5'h09, 17'h0);
    push(K_WORD, 5'h09, 17'h00000);
    run_frame(mk(2'b01, 2'b10, 5'd1, 5'h09, 16'h0000), 32, 1'b1, 1'b0);

    push(K_RD, 5'h03, 17'h0);
    run_frame(mk(2'b01, 2'b10, 5'd1, 5'h03, 16'h0000), 24, 1'b1, 1'b1);
    push(K_RD, 5'h03, 17'h0);
    push(K_WORD, 5'h03, {1'b0, 16'hBEEF});
    run_frame(mk(2'b01, 2'b10, 5'd1, 5'h03, 16'h0000), 32, 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
